commit_trace_buffer: RTL

Retire-side trace buffer that sits directly downstream of the core top-level. Each cycle it samples the core's commit outputs (pc, instruction, register write-back, memory address/data, stall/flush flags) and qualifies a retired instruction. It stamps each retire with a sequence number and queues it in a FIFO. The queue drains to a trace sink over a valid/ready handshake, and overflow is reported with a drop counter.

---
 rtl/commit_trace_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// Retire-side trace buffer: qualifies commits, stamps sequence numbers,
// queues records in a show-ahead FIFO and drains them over valid/ready.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQW  = 32,
  parameter int DROPW = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     stall_i,
  input  logic                     flushD_i,
  input  logic                     flushE_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [SEQW-1:0]          trace_seq_o,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [XLEN-1:0]          trace_reg_data_o,
  output logic [XLEN-1:0]          trace_mem_addr_o,
  output logic [XLEN-1:0]          trace_mem_data_o,
  output logic [4:0]               trace_reg_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [DROPW-1:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  rec_t             store [DEPTH];
  rec_t             head;
  rec_t             wrec;
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [CW-1:0]    count;
  logic [SEQW-1:0]  seq;
  logic             full;
  logic             empty;
  logic             retire;
  logic             push;
  logic             pop;
  logic             drop;

  assign count  = wptr - rptr;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  assign retire = enable_i & ~stall_i & ~flushD_i & ~flushE_i
                & (instr_i != '0);
  assign pop    = ~empty & trace_ready_i;
  assign push   = retire & (~full | pop);
  assign drop   = retire & full & ~pop;

  always_comb begin
    wrec          = '0;
    wrec.seq      = seq;
    wrec.pc       = pc_i;
    wrec.instr    = instr_i;
    wrec.reg_addr = reg_addr_i;
    wrec.reg_data = reg_data_i;
    wrec.mem_addr = mem_addr_i;
    wrec.mem_data = mem_data_i;
  end

  // Storage is deliberately unreset; head fields are ignored while empty.
  always_ff @(posedge clk_i) begin
    if (push)
      store[wptr[AW-1:0]] <= wrec;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
      seq  <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (retire)
        seq <= seq + 1'b1;
    end
  end

  // Clear wins over a same-cycle drop, but that drop still counts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_i) begin
      overflow_o <= drop;
      drop_cnt_o <= drop ? DROPW'(1) : '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1)
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  assign head             = store[rptr[AW-1:0]];
  assign trace_valid_o    = ~empty;
  assign trace_seq_o      = head.seq;
  assign trace_pc_o       = head.pc;
  assign trace_instr_o    = head.instr;
  assign trace_reg_addr_o = head.reg_addr;
  assign trace_reg_data_o = head.reg_data;
  assign trace_mem_addr_o = head.mem_addr;
  assign trace_mem_data_o = head.mem_data;
  assign count_o          = count;

endmodule
